// File: rtl/mqoi_pkg.sv
// Shared types and constants for the MQOI frame differ / undiffer pair.
package mqoi_pkg;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic [7:0] ALPHA_SAME   = 8'd0;
  localparam logic [7:0] ALPHA_OPAQUE = 8'd255;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } pixel_t;

  // Only "same as before" and "fully new" alpha codes are legal in the diff stream.
  function automatic logic alpha_illegal(input logic [7:0] a);
    return (a != ALPHA_SAME) && (a != ALPHA_OPAQUE);
  endfunction

endpackage

// File: rtl/mqoi_frame_counter.sv
// Pixel index within a frame: advances per accepted pixel, wraps at the frame end.
module mqoi_frame_counter
  import mqoi_pkg::*;
#(
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_W        = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [CNT_W-1:0] idx,
  output logic             is_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_d;

  // next index: hold, step, or wrap to zero after the last pixel
  always_comb begin
    idx_d = idx_q;
    if (adv) begin
      if (idx_q == LAST_IDX) begin
        idx_d = {CNT_W{1'b0}};
      end else begin
        idx_d = idx_q + ONE;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= {CNT_W{1'b0}};
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx     = idx_q;
  assign is_last = (idx_q == LAST_IDX);

endmodule

// File: rtl/mqoi_undiffer.sv
// Rebuilds the current frame from the diff stream and the previous-frame stream,
// tracking frame boundaries, the no-history (PRIME) condition and reuse statistics.
module mqoi_undiffer
  import mqoi_pkg::*;
#(
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_W        = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             diff_valid,
  output logic             diff_ready,
  input  logic [7:0]       diff_r,
  input  logic [7:0]       diff_g,
  input  logic [7:0]       diff_b,
  input  logic [7:0]       diff_a,
  input  logic             old_valid,
  output logic             old_ready,
  input  logic [7:0]       old_r,
  input  logic [7:0]       old_g,
  input  logic [7:0]       old_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_r,
  output logic [7:0]       out_g,
  output logic [7:0]       out_b,
  output logic [7:0]       out_a,
  output logic             out_last,
  output logic             frame_done,
  output logic [CNT_W-1:0] reused_count,
  input  logic             flush,
  output logic             protocol_err,
  input  logic             clear_err
);

  state_e           state_q,      state_d;
  logic             flush_pend_q, flush_pend_d;
  pixel_t           out_pix_q,    out_pix_d;
  logic             out_valid_q,  out_valid_d;
  logic             out_last_q,   out_last_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] reuse_cnt_q,  reuse_cnt_d;
  logic [CNT_W-1:0] reused_q,     reused_d;
  logic             err_q,        err_d;

  logic             can_load_s;
  logic             accept_s;
  logic             same_s;
  logic             is_first_s;
  logic             is_last_s;
  logic [CNT_W-1:0] pix_idx_s;
  logic [CNT_W-1:0] reuse_inc_s;
  pixel_t           old_pix_s;
  pixel_t           new_pix_s;

  mqoi_frame_counter #(
    .FRAME_PIXELS(FRAME_PIXELS),
    .CNT_W       (CNT_W)
  ) u_frame_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv    (accept_s),
    .idx    (pix_idx_s),
    .is_last(is_last_s)
  );

  assign is_first_s = (pix_idx_s == {CNT_W{1'b0}});

  // handshake: RUN joins both streams, PRIME consumes the diff stream alone
  always_comb begin
    can_load_s = !out_valid_q || out_ready;
    diff_ready = 1'b0;
    old_ready  = 1'b0;
    accept_s   = 1'b0;
    case (state_q)
      PRIME: begin
        diff_ready = can_load_s;
        old_ready  = 1'b0;
        accept_s   = diff_valid && can_load_s;
      end
      RUN: begin
        diff_ready = old_valid && can_load_s;
        old_ready  = diff_valid && can_load_s;
        accept_s   = diff_valid && old_valid && can_load_s;
      end
      default: begin
        diff_ready = 1'b0;
        old_ready  = 1'b0;
        accept_s   = 1'b0;
      end
    endcase
  end

  // pixel selection: alpha 0 reuses history (black when there is none)
  always_comb begin
    same_s = (diff_a == ALPHA_SAME);
    if (state_q == RUN) begin
      old_pix_s = '{r: old_r, g: old_g, b: old_b, a: ALPHA_OPAQUE};
    end else begin
      old_pix_s = '{r: 8'd0, g: 8'd0, b: 8'd0, a: ALPHA_OPAQUE};
    end
    if (same_s) begin
      new_pix_s = old_pix_s;
    end else begin
      new_pix_s = '{r: diff_r, g: diff_g, b: diff_b, a: ALPHA_OPAQUE};
    end
  end

  // output register: load on accept, drain on out_ready, otherwise hold
  always_comb begin
    out_pix_d    = out_pix_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = accept_s && is_last_s;
    if (accept_s) begin
      out_pix_d   = new_pix_s;
      out_valid_d = 1'b1;
      out_last_d  = is_last_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // reuse statistics and sticky protocol error (a new violation beats clear_err)
  always_comb begin
    reuse_inc_s = {{(CNT_W-1){1'b0}}, same_s};
    reuse_cnt_d = reuse_cnt_q;
    reused_d    = reused_q;
    if (accept_s) begin
      if (is_last_s) begin
        reused_d    = reuse_cnt_q + reuse_inc_s;
        reuse_cnt_d = {CNT_W{1'b0}};
      end else begin
        reuse_cnt_d = reuse_cnt_q + reuse_inc_s;
      end
    end else begin
      reuse_cnt_d = reuse_cnt_q;
    end
    if (accept_s && alpha_illegal(diff_a)) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // frame state: history becomes valid after a PRIME frame; flush drops it at a boundary
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      PRIME: begin
        flush_pend_d = 1'b0;
        if (accept_s && is_last_s) begin
          state_d = RUN;
        end else begin
          state_d = PRIME;
        end
      end
      RUN: begin
        if (accept_s && is_last_s) begin
          // a flush arriving with the last pixel still applies to the next frame
          state_d      = (flush_pend_q || flush) ? PRIME : RUN;
          flush_pend_d = 1'b0;
        end else if (flush && is_first_s && !accept_s) begin
          state_d      = PRIME;
          flush_pend_d = 1'b0;
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
      end
      default: begin
        state_d      = PRIME;
        flush_pend_d = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PRIME;
      flush_pend_q <= 1'b0;
      out_pix_q    <= '{r: 8'd0, g: 8'd0, b: 8'd0, a: 8'd0};
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      reuse_cnt_q  <= {CNT_W{1'b0}};
      reused_q     <= {CNT_W{1'b0}};
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      out_pix_q    <= out_pix_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      reuse_cnt_q  <= reuse_cnt_d;
      reused_q     <= reused_d;
      err_q        <= err_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_r        = out_pix_q.r;
  assign out_g        = out_pix_q.g;
  assign out_b        = out_pix_q.b;
  assign out_a        = out_pix_q.a;
  assign out_last     = out_last_q;
  assign frame_done   = frame_done_q;
  assign reused_count = reused_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_mqoi_undiffer.sv
// Directed bench for mqoi_undiffer with a transaction-level reference model.
module tb_mqoi_undiffer;

  localparam int FP = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic diff_valid, diff_ready, old_valid, old_ready, out_valid, out_ready;
  logic [7:0] diff_r, diff_g, diff_b, diff_a, old_r, old_g, old_b;
  logic [7:0] out_r, out_g, out_b, out_a;
  logic out_last, frame_done, flush, protocol_err, clear_err;
  logic [CW-1:0] reused_count;

  always #5 clk = ~clk;

  mqoi_undiffer #(.FRAME_PIXELS(FP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .diff_valid(diff_valid), .diff_ready(diff_ready),
    .diff_r(diff_r), .diff_g(diff_g), .diff_b(diff_b), .diff_a(diff_a),
    .old_valid(old_valid), .old_ready(old_ready),
    .old_r(old_r), .old_g(old_g), .old_b(old_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_a(out_a),
    .out_last(out_last), .frame_done(frame_done), .reused_count(reused_count),
    .flush(flush), .protocol_err(protocol_err), .clear_err(clear_err)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // model: pixels in flight ({last, rgba}), frame position, history flag, stats
  logic [32:0] exp_q[$];
  logic [31:0] out_log[$];
  bit m_prime, m_fpend, m_done, m_err;
  int m_idx, m_rc, m_reused;

  logic [31:0] exp_px [20] = '{
    {8'd10, 8'd20, 8'd30, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd255},
    {8'd1, 8'd2, 8'd3, 8'd255},    {8'd0, 8'd0, 8'd0, 8'd255},
    {8'd5, 8'd6, 8'd7, 8'd255},    {8'd9, 8'd9, 8'd9, 8'd255},
    {8'd5, 8'd6, 8'd7, 8'd255},    {8'd9, 8'd9, 8'd9, 8'd255},
    {8'd40, 8'd50, 8'd60, 8'd255}, {8'd40, 8'd50, 8'd60, 8'd255},
    {8'd7, 8'd7, 8'd7, 8'd255},    {8'd40, 8'd50, 8'd60, 8'd255},
    {8'd0, 8'd0, 8'd0, 8'd255},    {8'd11, 8'd12, 8'd13, 8'd255},
    {8'd2, 8'd2, 8'd2, 8'd255},    {8'd3, 8'd3, 8'd3, 8'd255},
    {8'd0, 8'd0, 8'd0, 8'd255},    {8'd0, 8'd0, 8'd0, 8'd255},
    {8'd0, 8'd0, 8'd0, 8'd255},    {8'd0, 8'd0, 8'd0, 8'd255}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prime = 1'b1; m_fpend = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_idx = 0; m_rc = 0; m_reused = 0;
  endtask

  task automatic compare();
    bit cl;
    cl = (exp_q.size() == 0) || out_ready;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_pixel", {out_r, out_g, out_b, out_a}, exp_q[0][31:0]);
      chk("out_last", 32'(out_last), 32'(exp_q[0][32]));
    end
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("reused_count", 32'(reused_count), 32'(m_reused));
    chk("protocol_err", 32'(protocol_err), 32'(m_err));
    chk("diff_ready", 32'(diff_ready), 32'(m_prime ? cl : (old_valid && cl)));
    chk("old_ready", 32'(old_ready), 32'(m_prime ? 1'b0 : (diff_valid && cl)));
  endtask

  // advance the model across the coming clock edge using the current inputs
  task automatic model_step();
    bit cl, acc, same, last;
    logic [31:0] px;
    cl  = (exp_q.size() == 0) || out_ready;
    acc = diff_valid && cl && (m_prime || old_valid);
    if (exp_q.size() != 0 && out_ready) begin
      void'(exp_q.pop_front());
      out_log.push_back({out_r, out_g, out_b, out_a});
    end
    m_done = 1'b0;
    if (acc && diff_a != 8'd0 && diff_a != 8'd255) m_err = 1'b1;
    else if (clear_err) m_err = 1'b0;
    last = (m_idx == FP - 1);
    if (acc) begin
      same = (diff_a == 8'd0);
      if (!same) px = {diff_r, diff_g, diff_b, 8'd255};
      else if (m_prime) px = {24'd0, 8'd255};
      else px = {old_r, old_g, old_b, 8'd255};
      exp_q.push_back({last, px});
      m_rc += int'(same);
    end
    if (acc && last) begin
      m_reused = m_rc; m_rc = 0; m_done = 1'b1; m_idx = 0;
      m_prime = m_prime ? 1'b0 : (m_fpend || flush);
      m_fpend = 1'b0;
    end else begin
      if (!m_prime && flush) begin
        if (m_idx == 0 && !acc) begin m_prime = 1'b1; m_fpend = 1'b0; end
        else m_fpend = 1'b1;
      end
      if (acc) m_idx++;
    end
  endtask

  task automatic tick(output bit hs);
    @(negedge clk);
    hs = diff_valid && diff_ready;
    if (!rst_n) begin
      model_reset();
    end else begin
      compare();
      if (frame_done) done_cnt++;
      model_step();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit h;
    repeat (n) tick(h);
  endtask

  task automatic xfer(input logic [31:0] d, input logic [23:0] o, input int old_delay, input int stall);
    int n;
    bit got;
    {diff_r, diff_g, diff_b, diff_a} = d;
    {old_r, old_g, old_b} = o;
    diff_valid = 1'b1;
    old_valid  = (old_delay == 0);
    out_ready  = (stall == 0);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick(got);
      n++;
      if (n >= old_delay) old_valid = 1'b1;
      if (n >= stall) out_ready = 1'b1;
    end
    chk("xfer_accept", 32'(got), 32'd1);
    diff_valid = 1'b0;
    old_valid  = 1'b0;
  endtask

  initial begin
    diff_valid = 1'b0; old_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; clear_err = 1'b0;
    {diff_r, diff_g, diff_b, diff_a} = 32'd0;
    {old_r, old_g, old_b} = 24'd0;
    model_reset();
    idle(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pixel", {out_r, out_g, out_b, out_a}, 32'd0);
    chk("rst_flags", {29'd0, out_last, frame_done, protocol_err}, 32'd0);
    chk("rst_reused", 32'(reused_count), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // frame 1: no history, old stream offered but must be ignored
    xfer({8'd10, 8'd20, 8'd30, 8'd255}, {8'd77, 8'd77, 8'd77}, 0, 0);
    xfer({8'd50, 8'd50, 8'd50, 8'd0},   {8'd77, 8'd77, 8'd77}, 0, 0);
    xfer({8'd1, 8'd2, 8'd3, 8'd255},    {8'd77, 8'd77, 8'd77}, 0, 0);
    xfer({8'd0, 8'd0, 8'd0, 8'd0},      {8'd77, 8'd77, 8'd77}, 0, 0);
    idle(2);
    chk("f1_reused", 32'(reused_count), 32'd2);
    chk("f1_done_pulses", 32'(done_cnt), 32'd1);

    // frame 2: history, with backpressure on pixel 2 and old-stream skew on pixel 3
    xfer({8'd1, 8'd1, 8'd1, 8'd0},   {8'd5, 8'd6, 8'd7}, 0, 0);
    xfer({8'd9, 8'd9, 8'd9, 8'd255}, {8'd5, 8'd6, 8'd7}, 0, 0);
    xfer({8'd1, 8'd1, 8'd1, 8'd0},   {8'd5, 8'd6, 8'd7}, 0, 3);
    xfer({8'd9, 8'd9, 8'd9, 8'd255}, {8'd5, 8'd6, 8'd7}, 2, 0);
    idle(2);
    chk("f2_reused", 32'(reused_count), 32'd2);

    // frame 3: flush at pixel 1 lets the frame finish with history
    xfer({8'd0, 8'd0, 8'd0, 8'd0}, {8'd40, 8'd50, 8'd60}, 0, 0);
    flush = 1'b1; idle(1); flush = 1'b0;
    xfer({8'd0, 8'd0, 8'd0, 8'd0},   {8'd40, 8'd50, 8'd60}, 0, 0);
    xfer({8'd7, 8'd7, 8'd7, 8'd255}, {8'd40, 8'd50, 8'd60}, 0, 0);
    xfer({8'd0, 8'd0, 8'd0, 8'd0},   {8'd40, 8'd50, 8'd60}, 0, 0);
    idle(2);
    chk("f3_reused", 32'(reused_count), 32'd3);

    // frame 4: back in PRIME, with illegal alpha codes
    xfer({8'd0, 8'd0, 8'd0, 8'd0},       {8'd99, 8'd99, 8'd99}, 0, 0);
    xfer({8'd11, 8'd12, 8'd13, 8'd128},  {8'd99, 8'd99, 8'd99}, 0, 0);
    clear_err = 1'b1;
    xfer({8'd2, 8'd2, 8'd2, 8'd1},       {8'd99, 8'd99, 8'd99}, 0, 0);
    clear_err = 1'b0;
    xfer({8'd3, 8'd3, 8'd3, 8'd255},     {8'd99, 8'd99, 8'd99}, 0, 0);
    idle(2);
    chk("f4_reused", 32'(reused_count), 32'd1);
    chk("f4_err_sticky", 32'(protocol_err), 32'd1);
    clear_err = 1'b1; idle(1); clear_err = 1'b0;
    chk("err_cleared", 32'(protocol_err), 32'd0);

    // flush while idle at pixel 0 of a RUN frame: immediate PRIME, all reuse -> black
    flush = 1'b1; idle(1); flush = 1'b0;
    repeat (4) xfer({8'd4, 8'd4, 8'd4, 8'd0}, {8'd99, 8'd99, 8'd99}, 0, 0);
    idle(2);
    chk("f5_reused", 32'(reused_count), 32'd4);
    chk("f5_done_pulses", 32'(done_cnt), 32'd5);

    for (int i = 0; i < 20; i++) chk($sformatf("out_seq%0d", i), out_log[i], exp_px[i]);

    // reset mid-frame: partial frame dropped, no frame_done for it
    xfer({8'd1, 8'd1, 8'd1, 8'd255}, {8'd2, 8'd2, 8'd2}, 0, 0);
    xfer({8'd1, 8'd1, 8'd1, 8'd0},   {8'd2, 8'd2, 8'd2}, 0, 0);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    idle(2);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_reused", 32'(reused_count), 32'd0);
    chk("midrst_done_pulses", 32'(done_cnt), 32'd5);
    repeat (4) xfer({8'd8, 8'd8, 8'd8, 8'd255}, {8'd2, 8'd2, 8'd2}, 0, 0);
    idle(2);
    chk("f6_done_pulses", 32'(done_cnt), 32'd6);
    chk("f6_reused", 32'(reused_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
